// File: rtl/imem_sync.sv
// Synchronous instruction memory with a valid/ready fetch port, fault reporting,
// branch flush and a run-time boot-load port. The read register maps onto iCE40 block RAM.
module imem_sync #(
    parameter int          DEPTH     = 256,
    parameter int          AW        = $clog2(DEPTH),
    parameter              INIT_FILE = "rtl/mems/memfile.dat",
    parameter logic [31:0] NOP_WORD  = 32'he1a00000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fetch_valid,
    input  logic [31:0]   fetch_addr,
    output logic          fetch_ready,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [31:0]   rd,
    output logic [31:0]   rd_addr,
    output logic          fault,
    input  logic          flush,
    input  logic          ld_start,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    input  logic          ld_done,
    output logic          ld_busy,
    output logic [15:0]   ld_count
);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_LOAD} state_t;
    // Selects what drives rd: the reset value, the RAM read register, or the fault NOP.
    typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_NOP} src_t;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   ram_q;

    state_t        state_q, state_d;
    src_t          src_q, src_d;
    logic          rd_valid_q, rd_valid_d;
    logic [31:0]   rd_addr_q, rd_addr_d;
    logic          fault_q, fault_d;
    logic          ld_busy_q, ld_busy_d;
    logic [15:0]   ld_count_q, ld_count_d;

    logic          accept;
    logic          range_err;
    logic          mis;
    logic          mem_we;
    logic [AW-1:0] fetch_idx;

    always_comb begin
        fetch_ready = (state_q == ST_RUN) && (!rd_valid_q || rd_ready);
        accept      = fetch_valid && fetch_ready;
        fetch_idx   = fetch_addr[AW+1:2];
        range_err   = (fetch_addr[31:AW+2] != '0);
        mis         = (fetch_addr[1:0] != 2'b00);
        mem_we      = (state_q == ST_LOAD) && ld_we;
    end

    // Block-RAM style array: write port owned by the loader, registered read on accept.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ld_addr] <= ld_data;
        end
        if (accept) begin
            ram_q <= mem[fetch_idx];
        end
    end

    always_comb begin
        rd_valid_d = rd_valid_q;
        rd_addr_d  = rd_addr_q;
        fault_d    = fault_q;
        src_d      = src_q;
        if (accept) begin
            rd_valid_d = 1'b1;
            rd_addr_d  = fetch_addr;
            fault_d    = range_err || mis;
            src_d      = range_err ? SRC_NOP : SRC_RAM;
        end else if (rd_ready || flush) begin
            rd_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (ld_start) begin
                    state_d = (rd_valid_q || accept) ? ST_DRAIN : ST_LOAD;
                end
            end
            ST_DRAIN: begin
                // No fetches are accepted here, so the held response is gone once rd_valid_d drops.
                if (!rd_valid_d) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ld_done) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        ld_busy_d  = (state_d != ST_RUN);
        ld_count_d = ld_count_q;
        if ((state_q != ST_LOAD) && (state_d == ST_LOAD)) begin
            ld_count_d = 16'd0;
        end else if (mem_we && (ld_count_q != 16'hFFFF)) begin
            ld_count_d = ld_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            src_q      <= SRC_ZERO;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= 32'd0;
            fault_q    <= 1'b0;
            ld_busy_q  <= 1'b0;
            ld_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
            fault_q    <= fault_d;
            ld_busy_q  <= ld_busy_d;
            ld_count_q <= ld_count_d;
        end
    end

    always_comb begin
        unique case (src_q)
            SRC_RAM: rd = ram_q;
            SRC_NOP: rd = NOP_WORD;
            default: rd = 32'd0;
        endcase
    end

    assign rd_valid = rd_valid_q;
    assign rd_addr  = rd_addr_q;
    assign fault    = fault_q;
    assign ld_busy  = ld_busy_q;
    assign ld_count = ld_count_q;

endmodule

// File: tb/tb_imem_sync.sv
// Bench for imem_sync: directed vector table, hand-written load/drain/reset sequences,
// then randomized traffic against a behavioural memory model.
module tb_imem_sync;

    localparam int          DEPTH = 256;
    localparam logic [31:0] NOP   = 32'he1a00000;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd;
    logic [31:0] rd_addr;
    logic        fault;
    logic        flush;
    logic        ld_start;
    logic        ld_we;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ld_done;
    logic        ld_busy;
    logic [15:0] ld_count;

    int n_tests = 0;
    int n_fail  = 0;

    imem_sync #(
        .DEPTH    (DEPTH),
        .INIT_FILE(""),
        .NOP_WORD (NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_valid(fetch_valid),
        .fetch_addr (fetch_addr),
        .fetch_ready(fetch_ready),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd         (rd),
        .rd_addr    (rd_addr),
        .fault      (fault),
        .flush      (flush),
        .ld_start   (ld_start),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_done    (ld_done),
        .ld_busy    (ld_busy),
        .ld_count   (ld_count)
    );

    always #5 clk = ~clk;

    // Reference model: the memory image, the one held response and the loader mode.
    logic [31:0] m_mem [DEPTH];
    bit          m_valid;
    logic [31:0] m_rd;
    logic [31:0] m_addr;
    bit          m_fault;
    bit          m_loading;
    bit          m_draining;
    int          m_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid    = 0;
        m_rd       = 32'd0;
        m_addr     = 32'd0;
        m_fault    = 0;
        m_loading  = 0;
        m_draining = 0;
        m_count    = 0;
    endtask

    // Drive one clock cycle, check the combinational ready against the model,
    // advance the model, then check every registered output after the edge.
    task automatic cycle(input bit fv, input logic [31:0] a, input bit rr, input bit fl,
                         input bit ls, input bit we, input logic [7:0] la,
                         input logic [31:0] ldv, input bit dn, output bit got_ready);
        bit exp_ready;
        bit acc;
        bit nxt_valid;
        fetch_valid = fv;
        fetch_addr  = a;
        rd_ready    = rr;
        flush       = fl;
        ld_start    = ls;
        ld_we       = we;
        ld_addr     = la;
        ld_data     = ldv;
        ld_done     = dn;
        #1;
        exp_ready = !m_loading && !m_draining && (!m_valid || rr);
        got_ready = fetch_ready;
        chk("fetch_ready", 32'(fetch_ready), 32'(exp_ready));
        acc = fv && exp_ready;
        nxt_valid = acc ? 1'b1 : ((rr || fl) ? 1'b0 : m_valid);
        if (acc) begin
            m_addr  = a;
            m_fault = (a >= DEPTH * 4) || ((a % 4) != 0);
            m_rd    = (a >= DEPTH * 4) ? NOP : m_mem[a / 4];
        end
        if (m_loading) begin
            if (we) begin
                m_mem[la] = ldv;
                if (m_count < 65535) m_count++;
            end
            if (dn) m_loading = 0;
        end else if (m_draining) begin
            if (!nxt_valid) begin
                m_draining = 0;
                m_loading  = 1;
                m_count    = 0;
            end
        end else if (ls) begin
            if (m_valid || acc) begin
                m_draining = 1;
            end else begin
                m_loading = 1;
                m_count   = 0;
            end
        end
        m_valid = nxt_valid;
        @(posedge clk);
        #1;
        chk("rd_valid", 32'(rd_valid), 32'(m_valid));
        chk("ld_busy", 32'(ld_busy), 32'(m_loading || m_draining));
        chk("ld_count", 32'(ld_count), 32'(m_count));
        if (m_valid) begin
            chk("rd", rd, m_rd);
            chk("rd_addr", rd_addr, m_addr);
            chk("fault", 32'(fault), 32'(m_fault));
        end
    endtask

    typedef struct {
        bit          fv;
        logic [31:0] addr;
        bit          rr;
        bit          fl;
        bit          e_ready;
        bit          e_valid;
        logic [31:0] e_rd;
        logic [31:0] e_addr;
        bit          e_fault;
    } vec_t;

    vec_t tbl [17];

    function automatic logic [31:0] boot_word(input int i);
        if (i == 0) return 32'he04f000f;
        if (i == 1) return 32'he2800001;
        return 32'hC0DE0000 + 32'(i);
    endfunction

    initial begin
        bit r;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
        model_reset();

        // flow, back-pressure hold, faults, flush
        tbl[0]  = '{1, 32'h0000_0000, 1, 0, 1, 1, 32'he04f000f, 32'h0000_0000, 0};
        tbl[1]  = '{1, 32'h0000_0004, 1, 0, 1, 1, 32'he2800001, 32'h0000_0004, 0};
        tbl[2]  = '{1, 32'h0000_0008, 1, 0, 1, 1, 32'hC0DE0002, 32'h0000_0008, 0};
        tbl[3]  = '{1, 32'h0000_000C, 0, 0, 0, 1, 32'hC0DE0002, 32'h0000_0008, 0};
        tbl[4]  = '{1, 32'h0000_000C, 0, 0, 0, 1, 32'hC0DE0002, 32'h0000_0008, 0};
        tbl[5]  = '{1, 32'h0000_000C, 0, 0, 0, 1, 32'hC0DE0002, 32'h0000_0008, 0};
        tbl[6]  = '{1, 32'h0000_000C, 1, 0, 1, 1, 32'hC0DE0003, 32'h0000_000C, 0};
        tbl[7]  = '{1, 32'h0000_0400, 1, 0, 1, 1, NOP,          32'h0000_0400, 1};
        tbl[8]  = '{1, 32'h0000_0006, 1, 0, 1, 1, 32'he2800001, 32'h0000_0006, 1};
        tbl[9]  = '{1, 32'h0000_03FC, 1, 0, 1, 1, 32'hC0DE00FF, 32'h0000_03FC, 0};
        tbl[10] = '{1, 32'hFFFF_FFFC, 1, 0, 1, 1, NOP,          32'hFFFF_FFFC, 1};
        tbl[11] = '{1, 32'h0000_0004, 0, 0, 0, 1, NOP,          32'hFFFF_FFFC, 1};
        tbl[12] = '{1, 32'h0000_000C, 1, 1, 1, 1, 32'hC0DE0003, 32'h0000_000C, 0};
        tbl[13] = '{0, 32'h0000_0000, 0, 1, 0, 0, 32'h0,        32'h0,         0};
        tbl[14] = '{0, 32'h0000_0000, 0, 1, 1, 0, 32'h0,        32'h0,         0};
        tbl[15] = '{1, 32'h0000_0010, 0, 0, 1, 1, 32'hC0DE0004, 32'h0000_0010, 0};
        tbl[16] = '{0, 32'h0000_0000, 1, 0, 1, 0, 32'h0,        32'h0,         0};

        reset = 1'b1;
        fetch_valid = 0; fetch_addr = 0; rd_ready = 0; flush = 0;
        ld_start = 0; ld_we = 0; ld_addr = 0; ld_data = 0; ld_done = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd", rd, 32'd0);
        chk("rst_rd_addr", rd_addr, 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_ld_busy", 32'(ld_busy), 32'd0);
        chk("rst_ld_count", 32'(ld_count), 32'd0);
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
        #1 reset = 1'b0;

        // Boot-load the whole image through the loader port.
        cycle(0, 0, 0, 0, 1, 0, 0, 0, 0, r);
        chk("boot_busy", 32'(ld_busy), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 0, 0, 0, 0, 1, 8'(i), boot_word(i), (i == DEPTH - 1), r);
        end
        chk("boot_count", 32'(ld_count), 32'd256);
        chk("boot_busy_done", 32'(ld_busy), 32'd0);

        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].fv, tbl[i].addr, tbl[i].rr, tbl[i].fl, 0, 0, 0, 0, 0, r);
            chk($sformatf("tbl%0d_ready", i), 32'(r), 32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_valid", i), 32'(rd_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_rd", i), rd, tbl[i].e_rd);
                chk($sformatf("tbl%0d_addr", i), rd_addr, tbl[i].e_addr);
                chk($sformatf("tbl%0d_fault", i), 32'(fault), 32'(tbl[i].e_fault));
            end
        end

        // Load request with a held response goes through DRAIN.
        cycle(1, 32'h8, 0, 0, 0, 0, 0, 0, 0, r);
        cycle(0, 0, 0, 0, 1, 0, 0, 0, 0, r);
        chk("drain_busy", 32'(ld_busy), 32'd1);
        chk("drain_hold_rd", rd, 32'hC0DE0002);
        cycle(1, 32'h0, 0, 0, 0, 0, 0, 0, 0, r);
        chk("drain_blocks_fetch", 32'(r), 32'd0);
        cycle(0, 0, 1, 0, 0, 0, 0, 0, 0, r);
        chk("load_entry_valid", 32'(rd_valid), 32'd0);
        chk("load_entry_count", 32'(ld_count), 32'd0);
        cycle(0, 0, 0, 0, 0, 1, 8'd0, 32'heafffffe, 0, r);
        cycle(0, 0, 0, 0, 0, 1, 8'd3, 32'h00000000, 1, r);
        chk("load_count2", 32'(ld_count), 32'd2);
        chk("load_done_busy", 32'(ld_busy), 32'd0);
        cycle(1, 32'h0, 1, 0, 0, 0, 0, 0, 0, r);
        chk("after_load_rd0", rd, 32'heafffffe);
        cycle(0, 0, 1, 0, 0, 1, 8'd1, 32'hDEADBEEF, 0, r);
        cycle(1, 32'h4, 1, 0, 0, 0, 0, 0, 0, r);
        chk("run_we_ignored", rd, 32'he2800001);
        chk("run_we_count", 32'(ld_count), 32'd2);
        cycle(1, 32'hC, 1, 0, 0, 0, 0, 0, 0, r);
        chk("after_load_rd3", rd, 32'h0);
        cycle(0, 0, 1, 0, 0, 0, 0, 0, 0, r);

        // Asynchronous reset in the middle of a load session.
        cycle(0, 0, 0, 0, 1, 0, 0, 0, 0, r);
        cycle(0, 0, 0, 0, 0, 1, 8'd5, 32'h12345678, 0, r);
        chk("pre_reset_count", 32'(ld_count), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(ld_busy), 32'd0);
        chk("mid_rst_count", 32'(ld_count), 32'd0);
        chk("mid_rst_valid", 32'(rd_valid), 32'd0);
        chk("mid_rst_rd", rd, 32'd0);
        chk("mid_rst_addr", rd_addr, 32'd0);
        chk("mid_rst_fault", 32'(fault), 32'd0);
        model_reset();
        #2 reset = 1'b0;
        cycle(1, 32'h14, 1, 0, 0, 0, 0, 0, 0, r);
        chk("write_persists", rd, 32'h12345678);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            int unsigned sel;
            logic [31:0] a;
            sel = $urandom_range(0, 99);
            if (sel < 60)      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            else if (sel < 75) a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
            else if (sel < 90) a = $urandom | 32'h0000_0400;
            else               a = sel[0] ? 32'h0000_03FC : 32'h0000_0400;
            cycle($urandom_range(0, 9) < 7, a, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 1) == 1, 8'($urandom_range(0, DEPTH - 1)),
                  $urandom, $urandom_range(0, 19) < 3, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
